// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial add/subtract engine.
// The producer/consumer side uses the master modport; the engine uses slave.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell reused LSB first over
// WIDTH cycles, carry held in a flop between bits. Subtraction is a + ~b + 1,
// so b is inverted at accept and the carry flop is seeded with sub.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             c_out_r;
    logic             overflow_r;

    logic             bit_a_s;
    logic             bit_b_s;
    logic             sum_bit_s;
    logic             carry_next_s;

    // Full-adder sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry output (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // The single shared adder cell works on the bit selected by the counter.
    assign bit_a_s      = a_r[cnt_r];
    assign bit_b_s      = b_r[cnt_r];
    assign sum_bit_s    = fa_sum(bit_a_s, bit_b_s, carry_r);
    assign carry_next_s = fa_carry(bit_a_s, bit_b_s, carry_r);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.overflow  = overflow_r;

    // Control FSM and serial datapath; every handshake/result output is a flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            c_out_r     <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        // sub only matters as the inverted b and the carry seed,
                        // so it needs no flop of its own after this edge.
                        a_r         <= bus.a;
                        b_r         <= bus.b ^ {WIDTH{bus.sub}};
                        carry_r     <= bus.sub;
                        cnt_r       <= CNT_ZERO;
                        sum_r       <= {WIDTH{1'b0}};
                        c_out_r     <= 1'b0;
                        overflow_r  <= 1'b0;
                        in_ready_r  <= 1'b0;
                        state_r     <= RUN;
                    end else begin
                        in_ready_r  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[cnt_r] <= sum_bit_s;
                    carry_r      <= carry_next_s;
                    if (cnt_r == LAST_BIT) begin
                        // carry_r is the carry into the MSB at this point.
                        c_out_r     <= carry_next_s;
                        overflow_r  <= carry_r ^ carry_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13, with a short
// back-to-back phase checked against a word-level arithmetic model.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    bit   have_acc = 1'b0;

    serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_adder_ctrl_if #(.WIDTH(13)) bus13 ();

    serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit w13, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic s);
        if (w13) begin
            bus13.in_valid = v; bus13.a = a[12:0]; bus13.b = b[12:0]; bus13.sub = s;
        end else begin
            bus8.in_valid = v; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.sub = s;
        end
    endtask

    task automatic set_out_ready(input bit w13, input logic r);
        if (w13) bus13.out_ready = r;
        else     bus8.out_ready  = r;
    endtask

    function automatic logic rd_in_ready(input bit w13);
        return w13 ? bus13.in_ready : bus8.in_ready;
    endfunction
    function automatic logic rd_out_valid(input bit w13);
        return w13 ? bus13.out_valid : bus8.out_valid;
    endfunction
    function automatic logic [63:0] rd_sum(input bit w13);
        return w13 ? 64'(bus13.sum) : 64'(bus8.sum);
    endfunction
    function automatic logic rd_c(input bit w13);
        return w13 ? bus13.c_out : bus8.c_out;
    endfunction
    function automatic logic rd_ovf(input bit w13);
        return w13 ? bus13.overflow : bus8.overflow;
    endfunction

    // Called at a negedge; returns at a negedge with the engine back in IDLE.
    task automatic run_op(input bit w13, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [63:0] es, input logic ec,
                          input logic ev, input int hold, input bit rnd, input string tag);
        int w;
        int n;
        int stall;
        w = w13 ? 13 : 8;
        set_in(w13, 1'b1, a, b, s);
        n = 0;
        while (rd_in_ready(w13) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 64'(n < 100), 64'd1);
        @(negedge clk);
        // Scramble operands: the engine must not sample them after accept.
        set_in(w13, 1'b0, ~a, ~b, ~s);
        check({tag, "_in_ready_low"}, 64'(rd_in_ready(w13)), 64'd0);
        if (have_acc) check({tag, "_interval"}, 64'((cyc - last_acc) >= (w + 2)), 64'd1);
        have_acc = 1'b1;
        last_acc = cyc;
        repeat (w - 1) @(negedge clk);
        check({tag, "_early"}, 64'(rd_out_valid(w13)), 64'd0);
        @(negedge clk);
        check({tag, "_latency"}, 64'(rd_out_valid(w13)), 64'd1);
        check({tag, "_sum"}, rd_sum(w13), es);
        check({tag, "_c_out"}, 64'(rd_c(w13)), 64'(ec));
        check({tag, "_ovf"}, 64'(rd_ovf(w13)), 64'(ev));
        stall = rnd ? int'($urandom_range(0, 3)) : hold;
        repeat (stall) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(rd_out_valid(w13)), 64'd1);
            check({tag, "_hold_sum"}, rd_sum(w13), es);
            check({tag, "_hold_in_ready"}, 64'(rd_in_ready(w13)), 64'd0);
        end
        set_out_ready(w13, 1'b1);
        @(negedge clk);
        set_out_ready(w13, 1'b0);
        check({tag, "_drain_valid"}, 64'(rd_out_valid(w13)), 64'd0);
        check({tag, "_drain_in_ready"}, 64'(rd_in_ready(w13)), 64'd1);
    endtask

    initial begin
        logic [63:0] mask;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] bb;
        logic [63:0] es;
        logic [64:0] full;
        logic        rs;
        logic        ec;
        logic        ev;
        int          w;

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        set_in(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        set_out_ready(1'b0, 1'b0);
        set_out_ready(1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_sum", 64'(bus8.sum), 64'd0);
        check("rst_c_out", 64'(bus8.c_out), 64'd0);
        check("rst_ovf", 64'(bus8.overflow), 64'd0);
        check("rst13_in_ready", 64'(bus13.in_ready), 64'd1);
        check("rst13_out_valid", 64'(bus13.out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // WIDTH=8 directed vectors
        run_op(1'b0, 64'h5A, 64'h3C, 1'b0, 64'h96, 1'b0, 1'b1, 0, 1'b0, "add_5a_3c");
        run_op(1'b0, 64'h10, 64'h20, 1'b1, 64'hF0, 1'b0, 1'b0, 0, 1'b0, "sub_10_20");
        run_op(1'b0, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b0, "add_ff_01");
        run_op(1'b0, 64'h80, 64'h01, 1'b1, 64'h7F, 1'b1, 1'b1, 0, 1'b0, "sub_80_01");
        run_op(1'b0, 64'h00, 64'h00, 1'b1, 64'h00, 1'b1, 1'b0, 0, 1'b0, "sub_00_00");
        run_op(1'b0, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1, 5, 1'b0, "backpressure");

        // Reset in the middle of RUN (counter at bit 3)
        set_in(1'b0, 1'b1, 64'h5A, 64'h3C, 1'b0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        check("midrst_accepted", 64'(bus8.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("midrst_partial_sum", 64'(bus8.sum), 64'h06);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("midrst_sum", 64'(bus8.sum), 64'd0);
        check("midrst_in_ready", 64'(bus8.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        have_acc = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_result", 64'(bus8.out_valid), 64'd0);
        run_op(1'b0, 64'h01, 64'h01, 1'b0, 64'h02, 1'b0, 1'b0, 0, 1'b0, "after_rst");

        // WIDTH=13 directed vectors
        have_acc = 1'b0;
        run_op(1'b1, 64'h1FFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 0, 1'b0, "w13_wrap");
        run_op(1'b1, 64'h0FFF, 64'h0001, 1'b0, 64'h1000, 1'b0, 1'b1, 0, 1'b0, "w13_ovf");
        run_op(1'b1, 64'h0000, 64'h0001, 1'b1, 64'h1FFF, 1'b0, 1'b0, 2, 1'b0, "w13_borrow");

        // Back-to-back operations with random consumer stalls, both widths
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8 : 13;
            have_acc = 1'b0;
            mask = (64'd1 << w) - 64'd1;
            for (int i = 0; i < 120; i++) begin
                ra = {$urandom, $urandom} & mask;
                rb = {$urandom, $urandom} & mask;
                rs = 1'($urandom_range(0, 1));
                bb = rs ? (~rb & mask) : rb;
                full = {1'b0, ra} + {1'b0, bb} + 65'(rs);
                es = full[63:0] & mask;
                ec = full[w];
                ev = (ra[w-1] == bb[w-1]) && (es[w-1] != ra[w-1]);
                run_op(k == 1, ra, rb, rs, es, ec, ev, 0, 1'b1, (k == 0) ? "rnd8" : "rnd13");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
